// File: rtl/adxl362_spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adxl362_spi_ctrl                                             |
// | Description : SPI-slave command sequencer for the ADXL362 register bank.   |
// |               Oversamples SCLK/CS_N/MOSI in the clk_16mhz domain and       |
// |               decodes register-write and register-read commands. It        |
// |               drives the bank address, write strobe and write data with    |
// |               address auto-increment, and serialises read data onto MISO.  |
// | Ports       : clk_16mhz, rst_n (async, active low)                         |
// |               spi_sclk/spi_cs_n/spi_mosi in, spi_miso out (mode 0, MSB 1st)|
// |               reg_address[5:0], reg_write, reg_data_write[7:0] out         |
// |               reg_data_read[7:0] in (combinational from reg_address)       |
// |               busy, cmd_error out                                          |
// | Config      : define ADXL362_SPI_RO_PROTECT_EN to block writes to          |
// |               addresses 0x00-0x1E (cmd_error pulses instead of reg_write). |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module adxl362_spi_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CMD_WRITE   = 8'h0A,
   parameter logic [7:0] CMD_READ    = 8'h0B
) (
   input  logic       clk_16mhz,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [5:0] reg_address,
   output logic       reg_write,
   output logic [7:0] reg_data_write,
   input  logic [7:0] reg_data_read,
   output logic       busy,
   output logic       cmd_error
);

   localparam logic [5:0] RO_LAST = 6'h1E;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RDATA  = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

   state_t state, state_next;

   // Synchronisers; index 0 is the newest sample
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;

   logic [3:0] bit_cnt;
   logic [3:0] bit_cnt_inc;
   logic [6:0] shift_in;
   logic [7:0] byte_in;
   logic       byte_done;
   logic [7:0] shout;
   logic       dir_read;
   logic       inc_pend;
   logic [1:0] load_pipe;
   logic       wr_blocked;

   logic cmd_bad, addr_done, wdata_done, rdata_done;

   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
   assign cs_rise   = cs_sync[SYNC_STAGES-2] & ~cs_sync[SYNC_STAGES-1];
   assign cs_fall   = ~cs_sync[SYNC_STAGES-2] & cs_sync[SYNC_STAGES-1];
   // MOSI is taken one sample before the detected SCLK rise: in mode 0 it was
   // set up on the previous fall, so that sample is well inside the stable window.
   assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

   assign bit_cnt_inc = bit_cnt + 4'd1;
   assign byte_in     = {shift_in, mosi_bit};
   assign byte_done   = (state != ST_IDLE) && sclk_rise && (bit_cnt_inc == 4'd8);

`ifdef ADXL362_SPI_RO_PROTECT_EN
   assign wr_blocked = (reg_address <= RO_LAST);
`else
   assign wr_blocked = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_bad    = 1'b0;
      addr_done  = 1'b0;
      wdata_done = 1'b0;
      rdata_done = 1'b0;
      case (state)
         ST_IDLE:   if (cs_fall) state_next = ST_CMD;
         ST_CMD: begin
            if (byte_done) begin
               if ((byte_in == CMD_WRITE) || (byte_in == CMD_READ)) begin
                  state_next = ST_ADDR;
               end else begin
                  state_next = ST_IGNORE;
                  cmd_bad    = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (byte_done) begin
               addr_done  = 1'b1;
               state_next = dir_read ? ST_RDATA : ST_WDATA;
            end
         end
         ST_WDATA:  wdata_done = byte_done;
         ST_RDATA:  rdata_done = byte_done;
         ST_IGNORE: state_next = ST_IGNORE;
         default:   state_next = ST_IDLE;
      endcase
      // A byte completing together with CS_N rising is still committed above
      if (cs_rise) state_next = ST_IDLE;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt        <= '0;
         shift_in       <= '0;
         shout          <= '0;
         dir_read       <= 1'b0;
         inc_pend       <= 1'b0;
         load_pipe      <= '0;
         reg_address    <= '0;
         reg_write      <= 1'b0;
         reg_data_write <= '0;
         cmd_error      <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         inc_pend  <= 1'b0;
         cmd_error <= cmd_bad | (wdata_done & wr_blocked);
         // Read data is captured two cycles after every address change so the
         // bank has settled on the new address.
         load_pipe <= {load_pipe[0], addr_done | rdata_done};

         if (state == ST_IDLE) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            shift_in <= byte_in[6:0];
            bit_cnt  <= byte_done ? 4'd0 : bit_cnt_inc;
         end

         if ((state == ST_CMD) && byte_done) dir_read <= (byte_in == CMD_READ);

         if (addr_done)                    reg_address <= byte_in[5:0];
         else if (rdata_done || inc_pend)  reg_address <= reg_address + 6'd1;

         // Write strobe follows the byte by one cycle; the increment follows the strobe.
         if (wdata_done) begin
            reg_data_write <= byte_in;
            reg_write      <= ~wr_blocked;
            inc_pend       <= 1'b1;
         end

         // The fall with bit_cnt==0 trails the previous byte and must not shift.
         if (load_pipe[1])
            shout <= reg_data_read;
         else if ((state == ST_RDATA) && sclk_fall && (bit_cnt != 4'd0))
            shout <= {shout[6:0], 1'b0};
      end
   end

   assign spi_miso = (state == ST_RDATA) & shout[7];
   assign busy     = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adxl362_spi_ctrl                                          |
// | Description : Directed self-checking bench for adxl362_spi_ctrl. Acts as   |
// |               SPI master and register-bank model; logs write pulses and    |
// |               cmd_error pulses. Honours ADXL362_SPI_RO_PROTECT_EN.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adxl362_spi_ctrl;

   localparam int HALF = 80;   // SCLK half period = 8 clk_16mhz cycles

   logic       clk_16mhz = 1'b0;
   logic       rst_n;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic [5:0] reg_address;
   logic       reg_write;
   logic [7:0] reg_data_write;
   logic [7:0] reg_data_read;
   logic       busy;
   logic       cmd_error;

   logic [7:0] bank [64];
   assign reg_data_read = bank[reg_address];

   always #5 clk_16mhz = ~clk_16mhz;

   adxl362_spi_ctrl dut (
      .clk_16mhz      (clk_16mhz),
      .rst_n          (rst_n),
      .spi_sclk       (spi_sclk),
      .spi_cs_n       (spi_cs_n),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .reg_address    (reg_address),
      .reg_write      (reg_write),
      .reg_data_write (reg_data_write),
      .reg_data_read  (reg_data_read),
      .busy           (busy),
      .cmd_error      (cmd_error)
   );

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   int w0, e0;
   logic [7:0] rx, dummy;
   logic [5:0] wr_addr_log [32];
   logic [7:0] wr_data_log [32];

   // Every high cycle is logged, so a stretched pulse shows up as an extra write.
   always @(negedge clk_16mhz) begin
      if (rst_n) begin
         if (reg_write) begin
            if (wr_cnt < 32) begin
               wr_addr_log[wr_cnt] = reg_address;
               wr_data_log[wr_cnt] = reg_data_write;
            end
            wr_cnt++;
         end
         if (cmd_error) err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxd);
      rxd = 8'h00;
      for (int i = 7; i >= 8 - n; i--) begin
         spi_mosi = tx[i];
         #HALF;
         spi_sclk = 1'b1;
         rxd[i]   = spi_miso;
         #HALF;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxd);
      spi_bits(tx, 8, rxd);
   endtask

   task automatic cs_start;
      spi_cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_end;
      #HALF;
      spi_cs_n = 1'b1;
      #(4*HALF);
   endtask

   task automatic mark;
      w0 = wr_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) bank[i] = 8'h00;
      bank[0] = 8'hAD;
      bank[1] = 8'h1D;
      rst_n    = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      #42;
      check("rst_miso",  spi_miso, 0);
      check("rst_addr",  reg_address, 0);
      check("rst_wr",    reg_write, 0);
      check("rst_wdata", reg_data_write, 0);
      check("rst_busy",  busy, 0);
      check("rst_err",   cmd_error, 0);
      rst_n = 1'b1;
      #100;

      // 1: simple write
      mark();
      cs_start();
      spi_byte(8'h0A, rx);
      check("t1_miso_cmd", rx, 8'h00);
      check("t1_busy", busy, 1);
      spi_byte(8'h20, dummy);
      spi_byte(8'h55, dummy);
      check("t1_nwr", wr_cnt - w0, 1);
      check("t1_addr", wr_addr_log[w0], 8'h20);
      check("t1_data", wr_data_log[w0], 8'h55);
      check("t1_inc", reg_address, 8'h21);
      cs_end();
      check("t1_busy_end", busy, 0);
      check("t1_nerr", err_cnt - e0, 0);

      // 2: burst read 0xAD @0x00, 0x1D @0x01
      mark();
      cs_start();
      spi_byte(8'h0B, dummy);
      spi_byte(8'h00, dummy);
      spi_byte(8'h00, rx);
      check("t2_rd0", rx, 8'hAD);
      spi_byte(8'h00, rx);
      check("t2_rd1", rx, 8'h1D);
      cs_end();
      check("t2_addr", reg_address, 8'h02);
      check("t2_nwr", wr_cnt - w0, 0);
      check("t2_miso_idle", spi_miso, 0);

      // 3: write burst across the address wrap
      mark();
      cs_start();
      spi_byte(8'h0A, dummy);
      spi_byte(8'h3F, dummy);
      spi_byte(8'h11, dummy);
      spi_byte(8'h22, dummy);
      cs_end();
      check("t3_addr0", wr_addr_log[w0], 8'h3F);
      check("t3_data0", wr_data_log[w0], 8'h11);
`ifdef ADXL362_SPI_RO_PROTECT_EN
      check("t3_nwr", wr_cnt - w0, 1);
      check("t3_nerr", err_cnt - e0, 1);
`else
      check("t3_nwr", wr_cnt - w0, 2);
      check("t3_addr1", wr_addr_log[w0+1], 8'h00);
      check("t3_data1", wr_data_log[w0+1], 8'h22);
      check("t3_nerr", err_cnt - e0, 0);
`endif
      check("t3_addr_end", reg_address, 8'h01);

      // 4: unknown command, then a normal write
      mark();
      cs_start();
      spi_byte(8'h0C, dummy);
      spi_byte(8'hA5, rx);
      check("t4_miso_ign", rx, 8'h00);
      check("t4_busy_ign", busy, 1);
      cs_end();
      check("t4_nerr", err_cnt - e0, 1);
      check("t4_nwr_ign", wr_cnt - w0, 0);
      mark();
      cs_start();
      spi_byte(8'h0A, dummy);
      spi_byte(8'h2D, dummy);
      spi_byte(8'h02, dummy);
      cs_end();
      check("t4_nwr", wr_cnt - w0, 1);
      check("t4_addr", wr_addr_log[w0], 8'h2D);
      check("t4_data", wr_data_log[w0], 8'h02);
      check("t4_nerr2", err_cnt - e0, 0);

      // 6: write straddling the read-only boundary 0x1E/0x1F
      mark();
      cs_start();
      spi_byte(8'h0A, dummy);
      spi_byte(8'h1E, dummy);
      spi_byte(8'hFF, dummy);
      spi_byte(8'h01, dummy);
      cs_end();
`ifdef ADXL362_SPI_RO_PROTECT_EN
      check("t6_nwr", wr_cnt - w0, 1);
      check("t6_addr", wr_addr_log[w0], 8'h1F);
      check("t6_data", wr_data_log[w0], 8'h01);
      check("t6_nerr", err_cnt - e0, 1);
`else
      check("t6_nwr", wr_cnt - w0, 2);
      check("t6_addr0", wr_addr_log[w0], 8'h1E);
      check("t6_data0", wr_data_log[w0], 8'hFF);
      check("t6_addr1", wr_addr_log[w0+1], 8'h1F);
      check("t6_data1", wr_data_log[w0+1], 8'h01);
      check("t6_nerr", err_cnt - e0, 0);
`endif
      check("t6_addr_end", reg_address, 8'h20);

      // 5a: CS_N rises after 5 bits of a data byte
      mark();
      cs_start();
      spi_byte(8'h0A, dummy);
      spi_byte(8'h30, dummy);
      spi_bits(8'hAA, 5, dummy);
      cs_end();
      check("t5_partial_nwr", wr_cnt - w0, 0);
      check("t5_partial_nerr", err_cnt - e0, 0);
      check("t5_partial_wdata", reg_data_write, 8'h01);
      check("t5_partial_busy", busy, 0);

      // 5b: reset in the middle of a read, CS_N held low through release
      cs_start();
      spi_byte(8'h0B, dummy);
      spi_byte(8'h00, dummy);
      spi_bits(8'h00, 3, dummy);
      rst_n = 1'b0;
      #30;
      check("t5_rst_miso",  spi_miso, 0);
      check("t5_rst_addr",  reg_address, 0);
      check("t5_rst_wr",    reg_write, 0);
      check("t5_rst_wdata", reg_data_write, 0);
      check("t5_rst_busy",  busy, 0);
      check("t5_rst_err",   cmd_error, 0);
      #20;
      rst_n = 1'b1;
      #100;
      mark();
      spi_byte(8'h0A, dummy);
      check("t5_quiet_busy", busy, 0);
      spi_byte(8'h25, dummy);
      spi_byte(8'h77, dummy);
      check("t5_quiet_nwr", wr_cnt - w0, 0);
      check("t5_quiet_addr", reg_address, 0);
      cs_end();
      mark();
      cs_start();
      spi_byte(8'h0A, dummy);
      spi_byte(8'h25, dummy);
      spi_byte(8'h33, dummy);
      cs_end();
      check("t5_after_nwr", wr_cnt - w0, 1);
      check("t5_after_addr", wr_addr_log[w0], 8'h25);
      check("t5_after_data", wr_data_log[w0], 8'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
